// File: rtl/pipe_flush_pkg.sv
// rtl/pipe_flush_pkg.sv - shared types, stage indices and sizing helper for pipe_flush_ctrl
package pipe_flush_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    localparam int IF_STG  = 0;
    localparam int ID_STG  = 1;
    localparam int EX_STG  = 2;
    localparam int MEM_STG = 3;
    localparam int WB_STG  = 4;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_flush_ctrl_if.sv
// rtl/pipe_flush_ctrl_if.sv - pipeline-side control signals of the flush controller
interface pipe_flush_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int CTRL_W     = 10
);
    logic                  stall;
    logic [NUM_STAGES-1:0] flush_req;
    logic [CTRL_W-1:0]     ctrl_in;
    logic [CTRL_W-1:0]     ctrl_out;
    logic [NUM_STAGES-1:0] kill;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  busy;

    modport master (
        output stall, flush_req, ctrl_in,
        input  ctrl_out, kill, stage_valid, busy
    );

    modport slave (
        input  stall, flush_req, ctrl_in,
        output ctrl_out, kill, stage_valid, busy
    );
endinterface

// File: rtl/pipe_flush_drain_fsm.sv
// rtl/pipe_flush_drain_fsm.sv - redirect-penalty drain FSM: state, counter, busy, fetch suppress
module pipe_flush_drain_fsm
    import pipe_flush_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic flush_any,
    output logic busy,
    output logic suppress_fetch
);

    localparam int             CNT_W  = clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(1);
    localparam bit             MULTI  = (FLUSH_CYCLES > 1);

    drain_state_e     state;
    logic [CNT_W-1:0] cnt;

    // Fetch is held off whenever the next state is DRAIN.
    always_comb begin
        suppress_fetch = (MULTI && flush_any) || ((state == DRAIN) && (cnt != LAST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (MULTI && flush_any) begin
            state <= DRAIN;
            cnt   <= RELOAD;
            busy  <= 1'b1;
        end else if (state == DRAIN) begin
            cnt <= cnt - LAST;
            if (cnt == LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// rtl/pipe_flush_ctrl.sv - pipeline flush/bubble controller; optional PIPE_FLUSH_STATS_EN flush counter
module pipe_flush_ctrl
    import pipe_flush_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int DEC_STAGE    = ID_STG,
    parameter int CTRL_W       = 10,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_flush_ctrl_if.slave  pif
`ifdef PIPE_FLUSH_STATS_EN
    ,
    output logic [15:0]       flush_count
`endif
);

    logic [NUM_STAGES-1:0] stage_valid_q;
    logic [NUM_STAGES-1:0] valid_next;
    logic [NUM_STAGES-1:0] req_ok;
    logic [NUM_STAGES-1:0] kill_c;
    logic                  flush_any;
    logic                  stall_eff;
    logic                  suppress_fetch;
    logic                  busy_q;
    logic                  dec_live;

    // A request kills every strictly younger stage; the oldest requester's set covers all others.
    always_comb begin
        req_ok = pif.flush_req & stage_valid_q;
        kill_c = '0;
        for (int j = 0; j < NUM_STAGES - 1; j++) begin
            kill_c[j] = |(req_ok >> (j + 1));
        end
        flush_any = |req_ok;
        stall_eff = pif.stall & ~flush_any;
    end

    always_comb begin
        valid_next = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (k <= DEC_STAGE) begin
                valid_next[k] = stall_eff ? stage_valid_q[k] : (stage_valid_q[k-1] & ~kill_c[k-1]);
            end else if (k == DEC_STAGE + 1) begin
                valid_next[k] = stall_eff ? 1'b0 : (stage_valid_q[k-1] & ~kill_c[k-1]);
            end else begin
                valid_next[k] = stage_valid_q[k-1] & ~kill_c[k-1];
            end
        end
        if (suppress_fetch) begin
            valid_next[IF_STG] = 1'b0;
        end else if (stall_eff) begin
            valid_next[IF_STG] = stage_valid_q[IF_STG];
        end else begin
            valid_next[IF_STG] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid_q <= '0;
        end else begin
            stage_valid_q <= valid_next;
        end
    end

    pipe_flush_drain_fsm #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_drain_fsm (
        .clk            (clk),
        .reset          (reset),
        .flush_any      (flush_any),
        .busy           (busy_q),
        .suppress_fetch (suppress_fetch)
    );

    assign dec_live        = stage_valid_q[DEC_STAGE] & ~kill_c[DEC_STAGE];
    assign pif.ctrl_out    = pif.ctrl_in & {CTRL_W{dec_live}};
    assign pif.kill        = kill_c;
    assign pif.stage_valid = stage_valid_q;
    assign pif.busy        = busy_q;

`ifdef PIPE_FLUSH_STATS_EN
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_q <= '0;
        end else if (flush_any && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb/tb_pipe_flush_ctrl.sv - directed self-checking bench for pipe_flush_ctrl
module tb_pipe_flush_ctrl;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipe_flush_ctrl_if #(.NUM_STAGES(5), .CTRL_W(10)) if1 ();
    pipe_flush_ctrl_if #(.NUM_STAGES(5), .CTRL_W(10)) if3 ();

`ifdef PIPE_FLUSH_STATS_EN
    logic [15:0] fc1;
    logic [15:0] fc3;
`endif

    pipe_flush_ctrl #(.NUM_STAGES(5), .DEC_STAGE(1), .CTRL_W(10), .FLUSH_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .pif   (if1)
`ifdef PIPE_FLUSH_STATS_EN
        , .flush_count (fc1)
`endif
    );

    pipe_flush_ctrl #(.NUM_STAGES(5), .DEC_STAGE(1), .CTRL_W(10), .FLUSH_CYCLES(3)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .pif   (if3)
`ifdef PIPE_FLUSH_STATS_EN
        , .flush_count (fc3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refill1();
        for (int i = 0; i < 8 && if1.stage_valid !== 5'h1F; i++) tick();
        tests++;
        if (if1.stage_valid !== 5'h1F) begin
            $display("FAIL refill1: got %b expected 11111", if1.stage_valid); fails++;
        end
    endtask

    task automatic refill3();
        for (int i = 0; i < 8 && if3.stage_valid !== 5'h1F; i++) tick();
        tests++;
        if (if3.stage_valid !== 5'h1F) begin
            $display("FAIL refill3: got %b expected 11111", if3.stage_valid); fails++;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        if1.stall = 1'b0; if1.flush_req = '0; if1.ctrl_in = 10'h3FF;
        if3.stall = 1'b0; if3.flush_req = '0; if3.ctrl_in = 10'h3FF;
        tick(); tick();
        tests++;
        if (if1.stage_valid !== 5'b0) begin
            $display("FAIL reset_valid: got %b expected 00000", if1.stage_valid); fails++;
        end
        tests++;
        if (if1.kill !== 5'b0 || if1.ctrl_out !== 10'h0 || if1.busy !== 1'b0) begin
            $display("FAIL reset_outs: got kill=%b ctrl=%h busy=%b expected 0", if1.kill, if1.ctrl_out, if1.busy); fails++;
        end
        tests++;
        if (if3.stage_valid !== 5'b0 || if3.busy !== 1'b0) begin
            $display("FAIL reset_dut3: got valid=%b busy=%b expected 0", if3.stage_valid, if3.busy); fails++;
        end
    endtask

    task automatic test_fill();
        logic [4:0] seq [5];
        logic [4:0] e;
        logic [9:0] ec;
        seq = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
        rst1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            e  = seq[i];
            ec = e[1] ? 10'h3FF : 10'h000;
            tests++;
            if (if1.stage_valid !== e || if1.ctrl_out !== ec) begin
                $display("FAIL fill_%0d: got valid=%b ctrl=%h expected valid=%b ctrl=%h", i, if1.stage_valid, if1.ctrl_out, e, ec); fails++;
            end
        end
    endtask

    task automatic test_flush_ex();
        refill1();
        if1.flush_req = 5'b00100; #1;
        tests++;
        if (if1.kill !== 5'b00011 || if1.ctrl_out !== 10'h0) begin
            $display("FAIL flush_ex_kill: got kill=%b ctrl=%h expected kill=00011 ctrl=000", if1.kill, if1.ctrl_out); fails++;
        end
        tick(); if1.flush_req = '0;
        tests++;
        if (if1.stage_valid !== 5'b11001) begin
            $display("FAIL flush_ex_next: got %b expected 11001", if1.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if1.stage_valid !== 5'b10011) begin
            $display("FAIL flush_ex_next2: got %b expected 10011", if1.stage_valid); fails++;
        end
        if1.flush_req = 5'b00110; #1;
        tests++;
        if (if1.kill !== 5'b00001) begin
            $display("FAIL flush_inv_req: got %b expected 00001", if1.kill); fails++;
        end
        tick(); if1.flush_req = '0;
        tests++;
        if (if1.stage_valid !== 5'b00101) begin
            $display("FAIL flush_inv_next: got %b expected 00101", if1.stage_valid); fails++;
        end
    endtask

    task automatic test_oldest();
        refill1();
        if1.flush_req = 5'b00110; #1;
        tests++;
        if (if1.kill !== 5'b00011) begin
            $display("FAIL oldest_kill: got %b expected 00011", if1.kill); fails++;
        end
        tick(); if1.flush_req = '0;
    endtask

    task automatic test_stall();
        refill1();
        if1.stall = 1'b1;
        tick();
        tests++;
        if (if1.stage_valid !== 5'b11011) begin
            $display("FAIL stall_1: got %b expected 11011", if1.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if1.stage_valid !== 5'b10011) begin
            $display("FAIL stall_2: got %b expected 10011", if1.stage_valid); fails++;
        end
        if1.stall = 1'b0;
    endtask

    task automatic test_stall_flush();
        refill1();
        if1.stall = 1'b1; if1.flush_req = 5'b01000; #1;
        tests++;
        if (if1.kill !== 5'b00111) begin
            $display("FAIL stall_flush_kill: got %b expected 00111", if1.kill); fails++;
        end
        tick(); if1.stall = 1'b0; if1.flush_req = '0;
        tests++;
        if (if1.stage_valid !== 5'b10001) begin
            $display("FAIL stall_flush_next: got %b expected 10001", if1.stage_valid); fails++;
        end
    endtask

    task automatic test_wb_flush();
        refill1();
        if1.flush_req = 5'b10000; #1;
        tests++;
        if (if1.kill !== 5'b01111) begin
            $display("FAIL wb_kill: got %b expected 01111", if1.kill); fails++;
        end
        tick(); if1.flush_req = '0;
        tests++;
        if (if1.stage_valid !== 5'b00001 || if1.busy !== 1'b0) begin
            $display("FAIL wb_next: got valid=%b busy=%b expected 00001 busy=0", if1.stage_valid, if1.busy); fails++;
        end
        if1.flush_req = 5'b10000; #1;
        tests++;
        if (if1.kill !== 5'b00000) begin
            $display("FAIL unqualified_req: got %b expected 00000", if1.kill); fails++;
        end
        if1.flush_req = '0;
    endtask

    task automatic test_drain();
        rst3 = 1'b0;
        refill3();
        if3.flush_req = 5'b00100;
        tick(); if3.flush_req = '0;
        tests++;
        if (if3.busy !== 1'b1 || if3.stage_valid !== 5'b11000) begin
            $display("FAIL drain_c1: got busy=%b valid=%b expected busy=1 valid=11000", if3.busy, if3.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if3.busy !== 1'b1 || if3.stage_valid !== 5'b10000) begin
            $display("FAIL drain_c2: got busy=%b valid=%b expected busy=1 valid=10000", if3.busy, if3.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if3.busy !== 1'b0 || if3.stage_valid !== 5'b00001) begin
            $display("FAIL drain_c3: got busy=%b valid=%b expected busy=0 valid=00001", if3.busy, if3.stage_valid); fails++;
        end
    endtask

    task automatic test_drain_extend();
        refill3();
        if3.flush_req = 5'b00100;
        tick();
        if3.flush_req = 5'b01000;
        tick(); if3.flush_req = '0;
        tests++;
        if (if3.busy !== 1'b1 || if3.stage_valid !== 5'b10000) begin
            $display("FAIL extend_c1: got busy=%b valid=%b expected busy=1 valid=10000", if3.busy, if3.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if3.busy !== 1'b1 || if3.stage_valid !== 5'b00000) begin
            $display("FAIL extend_c2: got busy=%b valid=%b expected busy=1 valid=00000", if3.busy, if3.stage_valid); fails++;
        end
        tick();
        tests++;
        if (if3.busy !== 1'b0 || if3.stage_valid !== 5'b00001) begin
            $display("FAIL extend_c3: got busy=%b valid=%b expected busy=0 valid=00001", if3.busy, if3.stage_valid); fails++;
        end
    endtask

    task automatic test_drain_reset();
        refill3();
        if3.flush_req = 5'b00100;
        tick(); if3.flush_req = '0;
        tests++;
        if (if3.busy !== 1'b1) begin
            $display("FAIL drain_rst_pre: got busy=%b expected 1", if3.busy); fails++;
        end
        rst3 = 1'b1;
        tick();
        tests++;
        if (if3.busy !== 1'b0 || if3.stage_valid !== 5'b00000) begin
            $display("FAIL drain_rst: got busy=%b valid=%b expected busy=0 valid=00000", if3.busy, if3.stage_valid); fails++;
        end
        rst3 = 1'b0;
    endtask

`ifdef PIPE_FLUSH_STATS_EN
    task automatic test_stats();
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        tests++;
        if (fc1 !== 16'h0) begin
            $display("FAIL stats_reset: got %h expected 0000", fc1); fails++;
        end
        refill1();
        if1.flush_req = 5'b00001;
        tick(); tick(); tick();
        if1.flush_req = '0;
        tests++;
        if (fc1 !== 16'd3) begin
            $display("FAIL stats_count: got %h expected 0003", fc1); fails++;
        end
        force dut1.flush_cnt_q = 16'hFFFE;
        tick();
        release dut1.flush_cnt_q;
        if1.flush_req = 5'b00001;
        tick(); tick(); tick();
        if1.flush_req = '0;
        tests++;
        if (fc1 !== 16'hFFFF) begin
            $display("FAIL stats_sat: got %h expected ffff", fc1); fails++;
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_flush_ex();
        test_oldest();
        test_stall();
        test_stall_flush();
        test_wb_flush();
        test_drain();
        test_drain_extend();
        test_drain_reset();
`ifdef PIPE_FLUSH_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
